burst_dma_ram: RTL and testbench
================================

# burst_dma_ram

Parametrised single-clock RAM with a built-in burst DMA engine for the FC-layer datapath. It accepts one command at a time: base address, length and direction. It then streams that many words into memory over a valid/ready write channel, or out of memory over a valid/ready read channel. It reports completion with a one-cycle `done` pulse. It sits between the layer controller and the weight/activation storage, and replaces per-word read/write strobing with counted bursts under backpressure.

## Interface
- `DATA_W`, 8, word width in bits
- `ADDR_W`, 15, address width; depth = 2^ADDR_W words
- `LEN_W`, 8, burst-length field width; max burst = 2^LEN_W − 1 words

- `clk`  in  1  single clock, all state updates on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `start`  in  1  command strobe, sampled only in IDLE
- `dir`  in  1  0 = read (mem→`rd_*`), 1 = write (`wr_*`→mem)
- `base_addr`  in  ADDR_W  first word address
- `length`  in  LEN_W  number of words in the burst
- `busy`  out  1  high from the cycle after `start` is accepted until IDLE is re-entered
- `done`  out  1  one-cycle pulse at burst completion
- `wr_data`  in  DATA_W  write word
- `wr_valid`  in  1  write word present
- `wr_ready`  out  1  engine accepts write word
- `rd_data`  out  DATA_W  read word
- `rd_valid`  out  1  read word present
- `rd_ready`  in  1  consumer accepts read word

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- Command capture:
  - IDLE with `start`=1 latches `base_addr`, `length` and `dir` into the address register, remaining-count register and mode register.
  - Next state: WRITE or READ by `dir`, or DONE if `length`=0.
  - `start` outside IDLE is ignored.
- WRITE:
  - `wr_ready`=1.
  - Each beat (`wr_valid`&&`wr_ready`) writes `mem[addr]`, increments `addr` and decrements `remaining`.
  - The beat that brings `remaining` to 0 moves the FSM to DONE.
- READ:
  - The issue side reads `mem[addr]` whenever `remaining`>0 and the output buffer has a free slot counting in-flight reads. Each issue increments `addr` and decrements `remaining`.
  - RAM read data enters a 2-entry output buffer that drives `rd_*`.
  - The FSM goes to DONE when `remaining`=0, no read is in flight, and the buffer has drained (last beat accepted).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W. A burst crossing the top address wraps to 0, with no error.
- Memory contents are not reset and persist across bursts and across `RST`.
- `RST` mid-burst:
  - Returns the FSM to IDLE and empties the buffer.
  - No `done` pulse is generated.
  - Words already written stay written.
- Reset values: `busy`=0, `done`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0.

## Timing
- Command accept edge = T0. `busy`=1 from T0+1 and stays high through the DONE cycle.
- Write:
  - `wr_ready` is high from T0+1.
  - Throughput is one word per cycle while `wr_valid` is held.
  - `done` is high in the cycle after the last write edge.
- Read:
  - First issue at T0+1.
  - First `rd_valid` at T0+2.
  - One word per cycle with `rd_ready` held high.
  - `rd_data`/`rd_valid` hold stable while `rd_valid`&&!`rd_ready`.
  - No issue occurs when two words are buffered or in flight.
  - `done` is high in the cycle after the last `rd_valid`&&`rd_ready`.
- `length`=0: DONE at T0+1, no channel activity.
- `start` may be asserted in the same cycle `done` is high. It is ignored, because the FSM is not yet in IDLE.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE/WRITE/READ/DONE);
  - the `dir` encoding constants `DIR_READ`=0 and `DIR_WRITE`=1.
- Sub-module `rd_skid_fifo`: parametrised 2-entry valid/ready buffer (DATA_W). It exposes a `free` count for the issue logic.
- The RAM array is inferred in the top level as a synchronous-read memory.

## Test plan
- Write burst: base 0x0010, length 4, data 0xA1..0xA4 with `wr_valid` held → four beats, `done` at T0+5. Then read burst: base 0x0010, length 4, `rd_ready` held → 0xA1..0xA4 on consecutive cycles starting T0+2, `done` one cycle after the last beat.
- Read backpressure: `rd_ready` toggled 1,0,0,1,… over an 8-word burst → no word lost or duplicated, and `rd_data` is stable while stalled.
- Wrap-around: write base 0x7FFE, length 4 → words land at 0x7FFE, 0x7FFF, 0x0000, 0x0001, and a readback matches.
- Zero length: `start` with `length`=0 → `busy` high at T0+1, `done` pulse at T0+1, no `wr_ready` or `rd_valid`.
- Reset mid-burst: `RST` pulsed after 2 of 6 write beats → outputs return to reset values immediately, no `done`. A readback shows 2 words written and the other 4 locations unchanged.
- `start` while busy: second `start` during a read burst → ignored, and the first burst completes with the correct data and count.

Source files
------------

// File: rtl/burst_dma_ram_pkg.sv
// burst_dma_ram_pkg: FSM state encoding and transfer-direction constants
// shared by the burst DMA RAM and its testbench.
package burst_dma_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry valid/ready output buffer with fall-through of the
// incoming word when empty; the producer must respect the reported free count.
module rd_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        free
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    // An arriving word bypasses storage when the buffer is empty and it is taken at once
    assign pop       = count != 2'd0 && out_ready;
    assign push      = in_valid && !(count == 2'd0 && out_ready);
    assign out_valid = count != 2'd0 || in_valid;
    assign out_data  = count != 2'd0 ? slot0 : in_valid ? in_data : '0;
    assign free      = 2'd2 - count;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop) begin
                slot0 <= count == 2'd2 ? slot1 : in_data;
                if (count == 2'd2 && push)
                    slot1 <= in_data;
            end else if (push) begin
                if (count == 2'd0)
                    slot0 <= in_data;
                else
                    slot1 <= in_data;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/burst_dma_ram.sv
// burst_dma_ram: single-port RAM with a counted burst engine that streams words
// in over wr_* or out over rd_* under valid/ready backpressure.
module burst_dma_ram
    import burst_dma_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready
);

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;
    logic [DATA_W-1:0] ram_q;
    logic [1:0]        free;
    logic [1:0]        occ;
    logic              beat;
    logic              issue;
    logic              drained;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign wr_ready = state == WRITE;
    assign beat     = wr_ready && wr_valid;
    // Free slots must also cover the read currently coming out of the RAM
    assign issue    = state == READ && remaining != '0 && free > {1'b0, inflight};
    assign occ      = 2'd2 - free + {1'b0, inflight};
    assign drained  = occ == 2'd0 || (occ == 2'd1 && rd_ready);

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = length == '0 ? DONE : dir == DIR_WRITE ? WRITE : READ;
            WRITE:   if (beat && remaining == LEN_W'(1)) next = DONE;
            READ:    if (remaining == '0 && drained) next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= next;
            inflight <= issue;
            if (state == IDLE && start) begin
                addr      <= base_addr;
                remaining <= length;
            end else if (beat || issue) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    // Contents survive reset, so the array has no reset branch
    always_ff @(posedge clk) begin
        if (beat)
            mem[addr] <= wr_data;
        if (issue)
            ram_q <= mem[addr];
    end

    rd_skid_fifo #(.DATA_W(DATA_W)) u_rd_fifo (
        .clk       (clk),
        .RST       (RST),
        .in_data   (ram_q),
        .in_valid  (inflight),
        .out_data  (rd_data),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .free      (free)
    );

endmodule

// File: tb/tb_burst_dma_ram.sv
// tb_burst_dma_ram: directed and random bursts checked against a word-addressed
// memory model and the cycle rules of the burst engine.
module tb_burst_dma_ram;
    import burst_dma_ram_pkg::*;

    localparam int DEPTH = 32768;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [14:0] base_addr = '0;
    logic [7:0]  length = '0;
    logic        busy;
    logic        done;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0] model [int];

    burst_dma_ram #(.DATA_W(8), .ADDR_W(15), .LEN_W(8)) dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .dir       (dir),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic d, input logic [14:0] b, input logic [7:0] l);
        start = 1'b1;
        dir = d;
        base_addr = b;
        length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wr_burst(input logic [14:0] b, input int l, input bit hold, input logic [7:0] first);
        int n = 0;
        int k = 1;
        cmd(DIR_WRITE, b, 8'(l));
        chk("wr_busy", busy, 1);
        while (n < l && k < 600) begin
            wr_valid = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
            wr_data = hold ? first + 8'(n) : 8'($urandom);
            chk("wr_ready", wr_ready, 1);
            chk("wr_done_early", done, 0);
            chk("wr_no_rd_valid", rd_valid, 0);
            @(posedge clk); #1;
            if (wr_valid) begin
                model[(int'(b) + n) % DEPTH] = wr_data;
                n++;
            end
            k++;
        end
        wr_valid = 1'b0;
        chk("wr_beats", n, l);
        chk("wr_done", done, 1);
        chk("wr_busy_in_done", busy, 1);
        if (hold) chk("wr_done_cycle", k, l + 1);
        @(posedge clk); #1;
        chk("wr_done_pulse", done, 0);
        chk("wr_idle_busy", busy, 0);
        chk("wr_idle_ready", wr_ready, 0);
    endtask

    // mode 0: ready held, 1: ready pattern 1,0,0,1 repeating, 2: random ready
    task automatic rd_burst(input logic [14:0] b, input int l, input int mode, input bit spurious);
        int n = 0;
        int k = 1;
        int first = -1;
        int last_k = -1;
        logic pv = 1'b0;
        logic [7:0] pd = '0;
        cmd(DIR_READ, b, 8'(l));
        chk("rd_busy", busy, 1);
        while (n < l && k < 600) begin
            rd_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 1 || k % 4 == 0) : 1'($urandom_range(0, 1));
            if (spurious && k == 3) begin
                start = 1'b1;
                dir = DIR_WRITE;
                base_addr = ~b;
                length = 8'd7;
            end else begin
                start = 1'b0;
            end
            if (pv) begin
                chk("rd_stall_valid", rd_valid, 1);
                chk("rd_stall_data", rd_data, pd);
            end
            chk("rd_done_early", done, 0);
            chk("rd_no_wr_ready", wr_ready, 0);
            if (rd_valid && first < 0) first = k;
            if (rd_valid && rd_ready) begin
                chk("rd_data", rd_data, model[(int'(b) + n) % DEPTH]);
                if (mode == 0 && n > 0) chk("rd_back_to_back", k, last_k + 1);
                last_k = k;
                n++;
            end
            pv = rd_valid && !rd_ready;
            pd = rd_data;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        rd_ready = 1'b0;
        chk("rd_beats", n, l);
        if (mode == 0) chk("rd_first_valid", first, 2);
        chk("rd_done", done, 1);
        chk("rd_busy_in_done", busy, 1);
        chk("rd_drained", rd_valid, 0);
        if (spurious) begin
            start = 1'b1;
            dir = DIR_WRITE;
            length = 8'd5;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("rd_done_pulse", done, 0);
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_wr_ready", wr_ready, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        RST = 1'b0;
        @(posedge clk); #1;

        wr_burst(15'h0010, 4, 1, 8'hA1);
        rd_burst(15'h0010, 4, 0, 0);

        wr_burst(15'h0100, 8, 1, 8'h30);
        rd_burst(15'h0100, 8, 1, 0);

        wr_burst(15'h7FFE, 4, 1, 8'h61);
        rd_burst(15'h7FFE, 4, 0, 0);
        rd_burst(15'h0000, 2, 0, 0);

        for (int d = 0; d < 2; d++) begin
            cmd(1'(d), 15'h0200, 8'd0);
            chk("zl_busy", busy, 1);
            chk("zl_done", done, 1);
            chk("zl_wr_ready", wr_ready, 0);
            chk("zl_rd_valid", rd_valid, 0);
            @(posedge clk); #1;
            chk("zl_idle_busy", busy, 0);
            chk("zl_idle_done", done, 0);
        end

        wr_burst(15'h0300, 6, 1, 8'h50);
        cmd(DIR_WRITE, 15'h0300, 8'd6);
        wr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data = 8'hC0 + 8'(i);
            @(posedge clk); #1;
            model[16'h0300 + i] = wr_data;
        end
        wr_data = 8'hC2;
        RST = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_wr_ready", wr_ready, 0);
        chk("mrst_rd_valid", rd_valid, 0);
        chk("mrst_rd_data", rd_data, 0);
        wr_valid = 1'b0;
        @(posedge clk); #1;
        chk("mrst_no_done", done, 0);
        RST = 1'b0;
        @(posedge clk); #1;
        chk("mrst_after_done", done, 0);
        rd_burst(15'h0300, 6, 0, 0);

        wr_burst(15'h0400, 5, 1, 8'h11);
        rd_burst(15'h0400, 5, 0, 1);

        repeat (6) begin
            logic [14:0] b;
            int l;
            b = 15'($urandom);
            l = $urandom_range(1, 24);
            wr_burst(b, l, 0, 8'h00);
            rd_burst(b, l, 2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
